// File: rtl/trng_pkg.sv
// Shared constants for the TRNG byte packer and its output FIFO.
package trng_pkg;
   localparam int BYTE_W         = 8;
   localparam int DEPTH_DEF      = 4;
   localparam int RCT_CUTOFF_DEF = 16;
endpackage

// File: rtl/trng_sync_fifo.sv
// Single-clock FIFO with head-of-queue read, power-of-two depth.
module trng_sync_fifo #(
   parameter int  WIDTH = 8,
   parameter int  DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             wr_ok, rd_ok;

   // A push into a full FIFO is accepted only when the head leaves the same cycle.
   assign wr_ok = push && (!full || pop);
   assign rd_ok = pop && !empty;
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/trng_byte_packer.sv
// Packs whitened TRNG bits LSB-first into bytes and queues them in a FIFO.
// Define TRNG_RCT_EN to compile in the repetition-count health test.
module trng_byte_packer
   import trng_pkg::*;
#(
   parameter int DEPTH      = DEPTH_DEF,
   parameter int RCT_CUTOFF = RCT_CUTOFF_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic                       bit_in,
   input  logic                       bit_valid,
   output logic [BYTE_W-1:0]          byte_out,
   output logic                       byte_valid,
   input  logic                       byte_ready,
   output logic [$clog2(DEPTH+1)-1:0] fill,
   output logic                       overflow,
   output logic                       health_fail
);
   logic [2:0]        bit_cnt;
   logic [BYTE_W-2:0] part;
   logic              accept, push, pop, full, empty;
   logic [BYTE_W-1:0] push_byte;

   assign accept     = enable && bit_valid && !health_fail;
   assign push       = accept && (bit_cnt == 3'd7);
   assign push_byte  = {bit_in, part};
   assign pop        = byte_valid && byte_ready;
   assign byte_valid = !empty;

   // The 8th bit goes straight into the pushed byte, so only 7 bits are stored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         part    <= '0;
      end else if (accept) begin
         bit_cnt <= bit_cnt + 1'b1;
         if (bit_cnt == 3'd7) part <= '0;
         else                 part <= part | ((BYTE_W-1)'(bit_in) << bit_cnt);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     overflow <= 1'b0;
      else if (push && full && !pop)  overflow <= 1'b1;
   end

`ifdef TRNG_RCT_EN
   localparam int RW = $clog2(RCT_CUTOFF + 1);
   logic [RW-1:0] run, run_nxt;
   logic          last_bit;

   // run == 0 only before the first accepted bit; saturate at the cutoff.
   always_comb begin
      run_nxt = RW'(1);
      if (run != '0 && bit_in == last_bit)
         run_nxt = (run == RW'(RCT_CUTOFF)) ? run : run + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run         <= '0;
         last_bit    <= 1'b0;
         health_fail <= 1'b0;
      end else if (accept) begin
         run      <= run_nxt;
         last_bit <= bit_in;
         if (run_nxt == RW'(RCT_CUTOFF)) health_fail <= 1'b1;
      end
   end
`else
   assign health_fail = 1'b0;
`endif

   trng_sync_fifo #(
      .WIDTH (BYTE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   (push_byte),
      .pop   (pop),
      .dout  (byte_out),
      .full  (full),
      .empty (empty),
      .count (fill)
   );
endmodule

// File: tb/tb_trng_byte_packer.sv
// Randomized bench for trng_byte_packer against a queue-based reference model.
module tb_trng_byte_packer;
   localparam int DEPTH = 4;
   localparam int RCT   = 16;
   localparam int FW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, byte_ready = 1'b0;
   logic [7:0]    byte_out;
   logic          byte_valid, overflow, health_fail;
   logic [FW-1:0] fill;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   int         mbits[$];
   logic [7:0] mq[$];
   bit         movf, mhf;
   int         run;
   bit         last;

   always #5 clk = ~clk;

   trng_byte_packer #(.DEPTH(DEPTH), .RCT_CUTOFF(RCT)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .bit_in(bit_in),
      .bit_valid(bit_valid), .byte_out(byte_out), .byte_valid(byte_valid),
      .byte_ready(byte_ready), .fill(fill), .overflow(overflow),
      .health_fail(health_fail)
   );

   task automatic model_clear();
      mbits.delete(); mq.delete(); movf = 0; mhf = 0; run = 0; last = 0;
   endtask

   task automatic model_edge();
      bit         full_old, popv, pushv;
      logic [7:0] b;
      full_old = (mq.size() == DEPTH);
      popv     = (mq.size() != 0) && byte_ready;
      pushv    = 0;
      b        = 8'h00;
      if (enable && bit_valid && !mhf) begin
         mbits.push_back(int'(bit_in));
`ifdef TRNG_RCT_EN
         if (run > 0 && bit_in == last) run++; else run = 1;
         last = bit_in;
         if (run >= RCT) mhf = 1;
`endif
         if (mbits.size() == 8) begin
            for (int i = 0; i < 8; i++) b = b + 8'(mbits[i] << i);
            mbits.delete();
            pushv = 1;
         end
      end
      if (popv) void'(mq.pop_front());
      if (pushv) begin
         if (full_old && !popv) movf = 1;
         else mq.push_back(b);
      end
   endtask

   // inputs change at negedge; model follows each rising edge; checks at negedge
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; enable = 0; bit_valid = 0; byte_ready = 0; bit_in = 0;
      #3;
      model_clear();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send_bit(input logic b);
      enable = 1'b1; bit_valid = 1'b1; bit_in = b;
      cycle();
      bit_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", byte_valid); end
      n_tests++; if (fill !== '0) begin n_fail++; $display("FAIL reset_fill got %0d want 0", fill); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
      n_tests++; if (health_fail !== 1'b0) begin n_fail++; $display("FAIL reset_hf got %b want 0", health_fail); end
      n_tests++; if (byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h want 00", byte_out); end
   endtask

   task automatic test_lsb_order();
      logic [7:0] pat;
      pat = 8'b0100_1101;
      byte_ready = 0;
      for (int i = 0; i < 7; i++) send_bit(pat[i]);
      n_tests++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_early_valid got %b want 0", byte_valid); end
      send_bit(pat[7]);
      n_tests++; if (byte_valid !== 1'b1) begin n_fail++; $display("FAIL lsb_valid got %b want 1", byte_valid); end
      n_tests++; if (byte_out !== 8'h4D) begin n_fail++; $display("FAIL lsb_byte got %h want 4D", byte_out); end
      n_tests++; if (fill !== FW'(1)) begin n_fail++; $display("FAIL lsb_fill got %0d want 1", fill); end
      cycle();
      n_tests++; if (byte_out !== 8'h4D || byte_valid !== 1'b1) begin n_fail++; $display("FAIL lsb_hold got %h/%b want 4D/1", byte_out, byte_valid); end
      byte_ready = 1; cycle(); byte_ready = 0;
      n_tests++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL lsb_pop got %b want 0", byte_valid); end
   endtask

   task automatic test_enable_gating();
      logic [7:0] b;
      do_reset();
      b = 8'($urandom);
      for (int i = 0; i < 4; i++) send_bit(b[i]);
      enable = 0; bit_valid = 1;
      for (int i = 0; i < 10; i++) begin bit_in = 1'($urandom); cycle(); end
      n_tests++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL gate_valid got %b want 0", byte_valid); end
      for (int i = 4; i < 8; i++) send_bit(b[i]);
      n_tests++; if (fill !== FW'(1)) begin n_fail++; $display("FAIL gate_fill got %0d want 1", fill); end
      n_tests++; if (byte_out !== b) begin n_fail++; $display("FAIL gate_byte got %h want %h", byte_out, b); end
   endtask

   task automatic test_overflow();
      logic [7:0] first;
      do_reset();
      first = 8'($urandom);
      send_byte(first);
      for (int k = 0; k < DEPTH; k++) send_byte(8'($urandom));
      n_tests++; if (fill !== FW'(DEPTH)) begin n_fail++; $display("FAIL ovf_fill got %0d want %0d", fill, DEPTH); end
      n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %b want 1", overflow); end
      n_tests++; if (byte_out !== first) begin n_fail++; $display("FAIL ovf_head got %h want %h", byte_out, first); end
      byte_ready = 1;
      for (int k = 0; k < DEPTH + 2 && mq.size() != 0; k++) begin
         n_tests++; if (byte_out !== mq[0]) begin n_fail++; $display("FAIL ovf_drain got %h want %h", byte_out, mq[0]); end
         cycle();
      end
      byte_ready = 0;
      n_tests++; if (overflow !== 1'b1 || fill !== '0) begin n_fail++; $display("FAIL ovf_sticky got %b/%0d want 1/0", overflow, fill); end
   endtask

   task automatic test_full_push_pop();
      logic [7:0] exp[$];
      logic [7:0] b;
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin b = 8'($urandom); exp.push_back(b); send_byte(b); end
      b = 8'($urandom);
      for (int i = 0; i < 7; i++) send_bit(b[i]);
      byte_ready = 1;
      send_bit(b[7]);
      byte_ready = 0;
      void'(exp.pop_front()); exp.push_back(b);
      n_tests++; if (fill !== FW'(DEPTH)) begin n_fail++; $display("FAIL fpp_fill got %0d want %0d", fill, DEPTH); end
      n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %b want 0", overflow); end
      byte_ready = 1;
      for (int k = 0; k < DEPTH; k++) begin
         n_tests++; if (byte_valid !== 1'b1 || byte_out !== exp[k]) begin n_fail++; $display("FAIL fpp_order got %h/%b want %h/1", byte_out, byte_valid, exp[k]); end
         cycle();
      end
      byte_ready = 0;
      n_tests++; if (fill !== '0) begin n_fail++; $display("FAIL fpp_empty got %0d want 0", fill); end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) send_bit(1'($urandom));
      #2 rst_n = 1'b0;
      #2 model_clear();
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      send_byte(8'hFF);
      n_tests++; if (fill !== FW'(1) || byte_out !== 8'hFF) begin n_fail++; $display("FAIL rmid_byte got %h fill %0d want FF fill 1", byte_out, fill); end
      n_tests++; if (overflow !== 1'b0 || health_fail !== 1'b0) begin n_fail++; $display("FAIL rmid_flags got %b%b want 00", overflow, health_fail); end
   endtask

   task automatic test_rct();
      do_reset();
      for (int i = 0; i < 16; i++) send_bit(1'b0);
`ifdef TRNG_RCT_EN
      n_tests++; if (health_fail !== 1'b1) begin n_fail++; $display("FAIL rct_hf got %b want 1", health_fail); end
      for (int i = 0; i < 8; i++) send_bit(1'($urandom));
      n_tests++; if (fill !== FW'(2)) begin n_fail++; $display("FAIL rct_ignore got fill %0d want 2", fill); end
`else
      n_tests++; if (health_fail !== 1'b0) begin n_fail++; $display("FAIL rct_off_hf got %b want 0", health_fail); end
`endif
      n_tests++; if (fill !== FW'(2)) begin n_fail++; $display("FAIL rct_fill got %0d want 2", fill); end
      byte_ready = 1;
      for (int k = 0; k < 2; k++) begin
         n_tests++; if (byte_valid !== 1'b1 || byte_out !== 8'h00) begin n_fail++; $display("FAIL rct_drain got %h/%b want 00/1", byte_out, byte_valid); end
         cycle();
      end
      byte_ready = 0;
      n_tests++; if (fill !== '0) begin n_fail++; $display("FAIL rct_empty got %0d want 0", fill); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 1500; c++) begin
         enable     = ($urandom_range(0, 9) < 8);
         bit_valid  = ($urandom_range(0, 9) < 7);
         bit_in     = 1'($urandom);
         byte_ready = (c < 700) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 3) != 0);
         cycle();
         n_tests++;
         if (byte_valid !== (mq.size() != 0) || fill !== FW'(mq.size()) ||
             overflow !== movf || health_fail !== mhf ||
             (mq.size() != 0 && byte_out !== mq[0])) begin
            n_fail++;
            $display("FAIL rand c=%0d got v%b f%0d o%b h%b b%h want v%b f%0d o%b h%b b%h", c,
                     byte_valid, fill, overflow, health_fail, byte_out,
                     mq.size() != 0, mq.size(), movf, mhf, (mq.size() != 0) ? mq[0] : 8'h00);
         end
      end
      enable = 0; bit_valid = 0; byte_ready = 0;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_lsb_order();
      test_enable_gating();
      test_overflow();
      test_full_push_pop();
      test_reset_mid();
      test_rct();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
